mod_dp: RTL and testbench

//  Datapath partner of the modulo control unit: computes a mod b and floor(a/b)
//  by repeated subtraction. Consumes the CU's write_temp/write_result strobes and

---
 rtl/mod_dp.sv | 88 ++++++++
 tb/tb_mod_dp.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mod_dp.sv
// -----------------------------------------------------------------------------
// mod_dp -- datapath half of the modulo control unit
//
// Computes a mod b and floor(a/b) by repeated subtraction. The control unit
// loads operands with write_temp, then strobes write_result once per cycle
// while it sits in its SUB state. It leaves SUB when less_than rises. A
// divisor of zero is flagged at load time and forces less_than high, so the
// control unit always terminates.
//
// Parameters
//   WIDTH         operand / remainder width
//   QWIDTH        quotient counter width; the counter saturates at all-ones
//
// Ports
//   clk           in   1       clock, rising edge
//   reset         in   1       synchronous, active-high
//   a_in          in   WIDTH   dividend, sampled when write_temp=1
//   b_in          in   WIDTH   divisor, sampled when write_temp=1
//   write_temp    in   1       load operands, clear quotient (wins over write_result)
//   write_result  in   1       perform one subtract step if less_than=0
//   less_than     out  1       remainder < divisor, or divide-by-zero
//   result        out  WIDTH   remainder register
//   quotient      out  QWIDTH  subtraction count
//   result_valid  out  1       result/quotient are final this cycle
//   div_by_zero   out  1       loaded divisor was zero
// -----------------------------------------------------------------------------
module mod_dp #(
    parameter int WIDTH  = 8,
    parameter int QWIDTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  a_in,
    input  logic [WIDTH-1:0]  b_in,
    input  logic              write_temp,
    input  logic              write_result,
    output logic              less_than,
    output logic [WIDTH-1:0]  result,
    output logic [QWIDTH-1:0] quotient,
    output logic              result_valid,
    output logic              div_by_zero
);

    logic [WIDTH-1:0]  r_temp;   // running remainder
    logic [WIDTH-1:0]  r_b;      // latched divisor
    logic [QWIDTH-1:0] r_quot;   // subtractions performed
    logic              r_dz;     // latched divisor was zero

    logic w_less_than;
    logic w_quot_max;
    logic w_step;

    // A zero divisor must look "done" immediately, otherwise temp >= 0 would
    // keep the control unit subtracting forever.
    assign w_less_than = r_dz | (r_temp < r_b);
    assign w_quot_max  = &r_quot;
    assign w_step      = write_result & ~write_temp & ~w_less_than;

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values of its neighbours regardless of order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_temp <= '0;
            r_b    <= '0;
            r_quot <= '0;
            r_dz   <= 1'b0;
        end else if (write_temp) begin
            r_temp <= a_in;
            r_b    <= b_in;
            r_quot <= '0;
            r_dz   <= (b_in == '0);
        end else if (w_step) begin
            // temp >= b here, so the difference never borrows.
            r_temp <= r_temp - r_b;
            // The remainder keeps converging even once the count is pinned.
            if (!w_quot_max) begin
                r_quot <= r_quot + 1'b1;
            end
        end
    end

    assign less_than    = w_less_than;
    assign result       = r_temp;
    assign quotient     = r_quot;
    assign div_by_zero  = r_dz;
    assign result_valid = ~reset & write_result & ~write_temp & w_less_than;

endmodule

// File: tb/tb_mod_dp.sv
module tb_mod_dp;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] a_in, b_in;
    logic       write_temp, write_result;

    logic       lt8, rv8, dz8;
    logic [7:0] res8, q8;
    logic       lt4, rv4, dz4;
    logic [7:0] res4;
    logic [3:0] q4;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mod_dp #(.WIDTH(8), .QWIDTH(8)) dut (
        .clk(clk), .reset(reset), .a_in(a_in), .b_in(b_in),
        .write_temp(write_temp), .write_result(write_result),
        .less_than(lt8), .result(res8), .quotient(q8),
        .result_valid(rv8), .div_by_zero(dz8)
    );

    mod_dp #(.WIDTH(8), .QWIDTH(4)) dut_q4 (
        .clk(clk), .reset(reset), .a_in(a_in), .b_in(b_in),
        .write_temp(write_temp), .write_result(write_result),
        .less_than(lt4), .result(res4), .quotient(q4),
        .result_valid(rv4), .div_by_zero(dz4)
    );

    // ---------------- reference model (plain arithmetic) ----------------
    function automatic int ref_rem(int a, int b);
        return (b == 0) ? a : a % b;
    endfunction

    function automatic int ref_quot(int a, int b, int qmax);
        int q;
        q = (b == 0) ? 0 : a / b;
        return (q > qmax) ? qmax : q;
    endfunction

    function automatic int ref_sub_cycles(int a, int b);
        return (b == 0) ? 0 : a / b;
    endfunction

    // Load cycle driven by the CU START state.
    task automatic load(input int a, input int b, input logic also_result);
        a_in         = 8'(a);
        b_in         = 8'(b);
        write_temp   = 1'b1;
        write_result = also_result;
        @(posedge clk); #1;
        write_temp   = 1'b0;
        write_result = 1'b0;
        a_in         = $urandom_range(0, 255);
        b_in         = $urandom_range(0, 255);
    endtask

    // SUB state until result_valid, then one END cycle; checks every step.
    task automatic run_sub(input int a, input int b, input string name);
        int k;
        int exp_rem;
        bit done;
        k = 0;
        done = 0;
        write_result = 1'b1;
        #1;
        while (!done) begin
            exp_rem = (b == 0) ? a : a - k * b;
            checks++;
            if (res8 !== 8'(exp_rem) || q8 !== 8'(ref_quot(k * b, b, 255)) ||
                res4 !== 8'(exp_rem) || q4 !== 4'(ref_quot(k * b, b, 15))) begin
                failures++;
                $display("FAIL %s step %0d: rem=%0d/%0d quot=%0d/%0d required rem=%0d quot=%0d/%0d",
                         name, k, res8, res4, q8, q4, exp_rem,
                         ref_quot(k * b, b, 255), ref_quot(k * b, b, 15));
            end
            if (rv8 === 1'b1) begin
                done = 1;
            end else if (k > 300) begin
                checks++;
                failures++;
                $display("FAIL %s timeout: result_valid never rose", name);
                done = 1;
            end else begin
                @(posedge clk); #1;
                k++;
            end
        end
        checks++;
        if (k != ref_sub_cycles(a, b)) begin
            failures++;
            $display("FAIL %s latency: sub_cycles=%0d required=%0d", name, k, ref_sub_cycles(a, b));
        end
        checks++;
        if (res8 !== 8'(ref_rem(a, b)) || q8 !== 8'(ref_quot(a, b, 255)) ||
            lt8 !== 1'b1 || dz8 !== (b == 0)) begin
            failures++;
            $display("FAIL %s final: rem=%0d quot=%0d lt=%b dz=%b required rem=%0d quot=%0d lt=1 dz=%0d",
                     name, res8, q8, lt8, dz8, ref_rem(a, b), ref_quot(a, b, 255), b == 0);
        end
        checks++;
        if (rv4 !== 1'b1 || res4 !== 8'(ref_rem(a, b)) || q4 !== 4'(ref_quot(a, b, 15)) ||
            dz4 !== (b == 0)) begin
            failures++;
            $display("FAIL %s final_q4: rv=%b rem=%0d quot=%0d dz=%b required rv=1 rem=%0d quot=%0d",
                     name, rv4, res4, q4, dz4, ref_rem(a, b), ref_quot(a, b, 15));
        end
        // END state: strobe stays high, everything must hold.
        @(posedge clk); #1;
        checks++;
        if (rv8 !== 1'b1 || res8 !== 8'(ref_rem(a, b)) || q8 !== 8'(ref_quot(a, b, 255))) begin
            failures++;
            $display("FAIL %s end_hold: rv=%b rem=%0d quot=%0d required rv=1 rem=%0d quot=%0d",
                     name, rv8, res8, q8, ref_rem(a, b), ref_quot(a, b, 255));
        end
        write_result = 1'b0;
    endtask

    task automatic run_op(input int a, input int b, input string name);
        load(a, b, 1'b0);
        run_sub(a, b, name);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        write_temp = 1'b0;
        write_result = 1'b0;
        a_in = 8'd0;
        b_in = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if (lt8 !== 1'b0 || res8 !== 8'd0 || q8 !== 8'd0 || rv8 !== 1'b0 || dz8 !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: lt=%b rem=%0d quot=%0d rv=%b dz=%b required all 0",
                     lt8, res8, q8, rv8, dz8);
        end
    endtask

    task automatic test_directed();
        run_op(17, 5, "a17_b5");
        run_op(3, 7, "a3_b7");
        run_op(9, 0, "a9_b0");
        run_op(255, 1, "a255_b1");
        run_op(0, 0, "a0_b0");
        run_op(200, 200, "a200_b200");
    endtask

    task automatic test_reset_mid_op();
        load(200, 3, 1'b0);
        write_result = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (rv8 !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid valid_gate: rv=%b required 0", rv8);
        end
        @(posedge clk); #1;
        checks++;
        if (res8 !== 8'd0 || q8 !== 8'd0 || rv8 !== 1'b0 || lt8 !== 1'b0 || dz8 !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid clear: rem=%0d quot=%0d rv=%b lt=%b dz=%b required all 0",
                     res8, q8, rv8, lt8, dz8);
        end
        reset = 1'b0;
        write_result = 1'b0;
        run_op(200, 3, "a200_b3_rerun");
    endtask

    task automatic test_both_strobes();
        load(10, 4, 1'b1);
        checks++;
        if (res8 !== 8'd10 || q8 !== 8'd0 || dz8 !== 1'b0) begin
            failures++;
            $display("FAIL both_strobes load: rem=%0d quot=%0d dz=%b required rem=10 quot=0 dz=0",
                     res8, q8, dz8);
        end
        // Load-and-strobe cycle must not flag completion either.
        a_in = 8'd10;
        b_in = 8'd4;
        write_temp = 1'b1;
        write_result = 1'b1;
        #1;
        checks++;
        if (rv8 !== 1'b0) begin
            failures++;
            $display("FAIL both_strobes valid: rv=%b required 0", rv8);
        end
        @(posedge clk); #1;
        write_temp = 1'b0;
        write_result = 1'b0;
        run_sub(10, 4, "both_strobes_sub");
    endtask

    task automatic test_idle_hold();
        load(50, 7, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (res8 !== 8'd50 || q8 !== 8'd0 || rv8 !== 1'b0) begin
            failures++;
            $display("FAIL idle_hold: rem=%0d quot=%0d rv=%b required rem=50 quot=0 rv=0",
                     res8, q8, rv8);
        end
        run_sub(50, 7, "idle_then_sub");
    endtask

    task automatic test_random();
        int a, b;
        for (int i = 0; i < 30; i++) begin
            a = $urandom_range(0, 255);
            b = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 255);
            if ($urandom_range(0, 3) == 0) b = $urandom_range(1, 4);
            run_op(a, b, $sformatf("rand%0d_a%0d_b%0d", i, a, b));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_mid_op();
        test_both_strobes();
        test_idle_hold();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
